// File: rtl/reg_mmr_scrub_pkg.sv
// Shared helpers for multi-bit modular-redundant registers: majority
// decision over a replica column and the saturating counter ceiling.
package mmr_pkg;

    // Largest replica count the majority helper can take.
    localparam int MAX_K = 31;

    // Returns 1 when more than k_i/2 of the first k_i bits of bits_i are set.
    function automatic logic popcount_gt_half(input logic [MAX_K-1:0] bits_i,
                                              input int               k_i);
        int ones;
        ones = 32'sd0;
        for (int i = 0; i < MAX_K; i++) begin
            if (i < k_i) begin
                ones = ones + int'(bits_i[i]);
            end else begin
                ones = ones;
            end
        end
        return (ones > (k_i / 32'sd2));
    endfunction

    // All-ones value of a width_i-bit counter (width_i must be below 64).
    function automatic logic [63:0] sat_max(input int width_i);
        return (64'd1 << width_i) - 64'd1;
    endfunction

endpackage

// File: rtl/reg_mmr_scrub_voter.sv
// Combinational bitwise majority voter over K_MMR replicas of a WIDTH-bit
// word, plus a per-replica "differs from the vote" vector.
import mmr_pkg::*;

module mmr_vector_voter #(
    parameter int K_MMR = 3,
    parameter int WIDTH = 8
) (
    input  logic [K_MMR-1:0][WIDTH-1:0] replica_i,
    output logic [WIDTH-1:0]            voted_o,
    output logic [K_MMR-1:0]            diff_o
);

    logic [WIDTH-1:0] w_voted;

    // Per bit: gather the column across replicas and take the majority.
    always_comb begin
        logic [MAX_K-1:0] col;
        w_voted = '0;
        for (int b = 0; b < WIDTH; b++) begin
            col = '0;
            for (int r = 0; r < K_MMR; r++) begin
                col[r] = replica_i[r][b];
            end
            w_voted[b] = popcount_gt_half(col, K_MMR);
        end
    end

    // Flag every replica whose word differs from the voted word.
    always_comb begin
        diff_o = '0;
        for (int r = 0; r < K_MMR; r++) begin
            diff_o[r] = (replica_i[r] != w_voted);
        end
    end

    assign voted_o = w_voted;

endmodule

// File: rtl/reg_mmr_scrub.sv
// K-modular-redundant register with majority vote, optional scrubbing of
// disagreeing replicas and mismatch/fault/error-count telemetry.
import mmr_pkg::*;

module reg_mmr_scrub #(
    parameter int               K_MMR       = 3,
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit               SCRUB_EN    = 1'b1,
    parameter int               CNT_WIDTH   = 16
) (
    input  logic                                        clk_i,
    input  logic                                        rst_n_i,
    (* dont_touch = "true" *) input logic [K_MMR-1:0][WIDTH-1:0] d_i,
    input  logic [K_MMR-1:0]                            we_i,
    input  logic                                        clr_i,
    output logic [K_MMR-1:0][WIDTH-1:0]                 q_o,
    output logic                                        mismatch_o,
    output logic [K_MMR-1:0]                            fault_o,
    output logic [CNT_WIDTH-1:0]                        err_cnt_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(sat_max(CNT_WIDTH));

    (* dont_touch = "true" *) logic [K_MMR-1:0][WIDTH-1:0] r_replica;
    logic [K_MMR-1:0][WIDTH-1:0] w_replica_nxt;
    logic [WIDTH-1:0]            w_voted;
    logic [K_MMR-1:0]            w_diff;
    logic                        w_mis;
    logic                        r_mismatch;
    logic [K_MMR-1:0]            r_fault;
    logic [CNT_WIDTH-1:0]        r_err_cnt;

    mmr_vector_voter #(
        .K_MMR (K_MMR),
        .WIDTH (WIDTH)
    ) u_voter (
        .replica_i (r_replica),
        .voted_o   (w_voted),
        .diff_o    (w_diff)
    );

    assign w_mis = |w_diff;

    // Replica next state: a write wins, otherwise scrub to the vote or hold.
    always_comb begin
        w_replica_nxt = r_replica;
        for (int r = 0; r < K_MMR; r++) begin
            if (we_i[r]) begin
                w_replica_nxt[r] = d_i[r];
            end else if (SCRUB_EN) begin
                w_replica_nxt[r] = w_voted;
            end else begin
                w_replica_nxt[r] = r_replica[r];
            end
        end
    end

    // Replica storage; reset loads RESET_VALUE into every copy.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_replica <= {K_MMR{RESET_VALUE}};
        end else begin
            r_replica <= w_replica_nxt;
        end
    end

    // Telemetry: registered mismatch, sticky faults, saturating counter.
    // A clear still records a disagreement seen in the same cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_mismatch <= 1'b0;
            r_fault    <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_mismatch <= w_mis;
            if (clr_i) begin
                r_fault   <= w_diff;
                r_err_cnt <= CNT_WIDTH'(w_mis);
            end else begin
                r_fault <= r_fault | w_diff;
                if (w_mis && (r_err_cnt != CNT_MAX)) begin
                    r_err_cnt <= r_err_cnt + CNT_WIDTH'(1'b1);
                end else begin
                    r_err_cnt <= r_err_cnt;
                end
            end
        end
    end

    // Every output lane carries the same voted word.
    always_comb begin
        q_o = '0;
        for (int r = 0; r < K_MMR; r++) begin
            q_o[r] = w_voted;
        end
    end

    assign mismatch_o = r_mismatch;
    assign fault_o    = r_fault;
    assign err_cnt_o  = r_err_cnt;

endmodule
